// File: rtl/gate_chk_pkg.sv
// Shared encodings and golden gate truth function for the gate-level response checkers.
package gate_chk_pkg;

   localparam int SETTLE_W = 4;

   typedef enum logic [2:0] {
      GSEL_NOT  = 3'd0,
      GSEL_AND  = 3'd1,
      GSEL_OR   = 3'd2,
      GSEL_NAND = 3'd3,
      GSEL_NOR  = 3'd4,
      GSEL_XOR  = 3'd5,
      GSEL_XNOR = 3'd6,
      GSEL_BUF  = 3'd7
   } gsel_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   function automatic logic golden_out(input logic [2:0] sel, input logic a, input logic b);
      logic y;
      y = 1'b0;
      case (gsel_e'(sel))
         GSEL_NOT:  y = ~a;
         GSEL_AND:  y = a & b;
         GSEL_OR:   y = a | b;
         GSEL_NAND: y = ~(a & b);
         GSEL_NOR:  y = ~(a | b);
         GSEL_XOR:  y = a ^ b;
         GSEL_XNOR: y = ~(a ^ b);
         GSEL_BUF:  y = a;
         default:   y = 1'b0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Golden gate function: expected output for the selected basic gate.
// Latency: purely combinational.
// Backpressure: none, evaluated every cycle.
module gate_golden_model
   import gate_chk_pkg::*;
(
   input  logic [2:0] sel,
   input  logic       a,
   input  logic       b,
   output logic       exp
);

   assign exp = golden_out(sel, a, b);

endmodule

// File: rtl/gate_response_checker.sv
// Judges a gate-under-test: waits for stable inputs, samples once, counts errors and coverage.
// Latency: sample SETTLE_CYCLES+1 cycles after the last input change, err_pulse one cycle later.
// Backpressure: none; optional first-mismatch capture under FIRST_FAIL_CAPTURE_EN.
module gate_response_checker
   import gate_chk_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int NUM_CHECKS    = 20,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [2:0]       gate_sel,
   input  logic             in1,
   input  logic             in2,
   input  logic             out_dut,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [3:0]       cov
`ifdef FIRST_FAIL_CAPTURE_EN
   ,
   output logic             ff_valid,
   output logic [2:0]       ff_vec,
   output logic [CNT_W-1:0] ff_idx
`endif
);

   localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

   state_e              state_q, state_d;
   logic [2:0]          sel_q;
   logic [1:0]          prev_q;
   logic [1:0]          in_vec;
   logic [SETTLE_W-1:0] settle_q;
   logic                exp_bit;
   logic                in_chg;
   logic                accept_start;
   logic                sample_en;
   logic                mismatch;
   logic                chk_done;
   logic [CNT_W-1:0]    chk_inc;
   logic [CNT_W-1:0]    err_inc;

   assign in_vec       = {in1, in2};
   assign in_chg       = (in_vec != prev_q);
   assign accept_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign mismatch     = sample_en && (out_dut != exp_bit);
   assign chk_inc      = (chk_cnt == CNT_MAX) ? chk_cnt : chk_cnt + CNT_W'(1);
   assign err_inc      = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_W'(1);
   // A saturated counter can never reach NUM_CHECKS, so such runs end only on stop.
   assign chk_done     = (32'(chk_inc) == 32'(NUM_CHECKS));

   gate_golden_model u_golden (
      .sel (sel_q),
      .a   (in1),
      .b   (in2),
      .exp (exp_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (stop)                                   state_d = ST_DONE;
            else if (!in_chg && settle_q <= SETTLE_W'(1)) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (stop || chk_done) state_d = ST_DONE;
            else if (in_chg)      state_d = ST_SETTLE;
            else                  state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (stop)        state_d = ST_DONE;
            else if (in_chg) state_d = ST_SETTLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      sample_en = 1'b0;
      case (state_q)
         ST_SETTLE, ST_HOLD: busy = 1'b1;
         ST_SAMPLE: begin
            busy      = 1'b1;
            sample_en = 1'b1;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Counters and coverage are frozen in DONE, so this is the final verdict.
   assign pass = done && (err_cnt == '0) && (cov == 4'hF) && (chk_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q     <= '0;
         prev_q    <= '0;
         settle_q  <= '0;
         chk_cnt   <= '0;
         err_cnt   <= '0;
         cov       <= '0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= mismatch;
         if (accept_start) begin
            sel_q    <= gate_sel;
            prev_q   <= in_vec;
            settle_q <= SETTLE_LD;
            chk_cnt  <= '0;
            err_cnt  <= '0;
            cov      <= '0;
         end else if (busy) begin
            if (in_chg) begin
               prev_q   <= in_vec;
               settle_q <= SETTLE_LD;
            end else if (state_q == ST_SETTLE && settle_q > SETTLE_W'(1)) begin
               settle_q <= settle_q - SETTLE_W'(1);
            end
            if (sample_en) begin
               chk_cnt      <= chk_inc;
               cov[in_vec]  <= 1'b1;
               if (mismatch) err_cnt <= err_inc;
            end
         end
      end
   end

`ifdef FIRST_FAIL_CAPTURE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff_valid <= 1'b0;
         ff_vec   <= '0;
         ff_idx   <= '0;
      end else if (accept_start) begin
         ff_valid <= 1'b0;
         ff_vec   <= '0;
         ff_idx   <= '0;
      end else if (mismatch && !ff_valid) begin
         ff_valid <= 1'b1;
         ff_vec   <= {in_vec, out_dut};
         ff_idx   <= chk_cnt;
      end
   end
`endif

endmodule
